// File: rtl/multiway_traffic_controller_pkg.sv
// Shared definitions for the intersection controller: phase encoding, lamp codes
// and the direction-index width helper.
package traffic_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_GREEN  = 2'd0;
    localparam phase_t PH_YELLOW = 2'd1;
    localparam phase_t PH_ALLRED = 2'd2;
    localparam phase_t PH_FLASH  = 2'd3;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic int dir_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiway_traffic_controller_if.sv
// Sensor-side requests and lamp-side outputs of the intersection controller.
interface multiway_traffic_controller_if
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS = 4,
    parameter int DIR_W    = dir_width(NUM_DIRS)
);
    logic [NUM_DIRS-1:0]   demand;
    logic                  flash_req;
    logic [3*NUM_DIRS-1:0] lights;
    logic [DIR_W-1:0]      active_dir;
    phase_t                phase;

    modport master (
        output demand, flash_req,
        input  lights, active_dir, phase
    );

    modport slave (
        input  demand, flash_req,
        output lights, active_dir, phase
    );
endinterface

// File: rtl/multiway_traffic_controller_rr_next_dir.sv
// Combinational round-robin picker: first requesting index after cur_i, wrapping.
// With no request, next_o echoes cur_i and valid_o is low.
module rr_next_dir
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS = 4,
    parameter int DIR_W    = dir_width(NUM_DIRS)
) (
    input  logic [NUM_DIRS-1:0] req_i,
    input  logic [DIR_W-1:0]    cur_i,
    output logic [DIR_W-1:0]    next_o,
    output logic                valid_o
);

    logic [DIR_W-1:0] idx;

    always_comb begin
        next_o  = cur_i;
        valid_o = 1'b0;
        idx     = '0;
        // Scan farthest offset first so the nearest requester is the last one written.
        for (int k = NUM_DIRS - 1; k >= 1; k--) begin
            idx = DIR_W'((32'(cur_i) + 32'(k)) % 32'(NUM_DIRS));
            if (req_i[idx]) begin
                next_o  = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiway_traffic_controller.sv
// Actuated multi-approach signal controller: demand-driven green with min/max limits,
// round-robin hand-over through yellow and all-red, and a flashing-red mode.
module multiway_traffic_controller
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS          = 4,
    parameter int MIN_GREEN_CYCLES  = 50,
    parameter int MAX_GREEN_CYCLES  = 200,
    parameter int YELLOW_CYCLES     = 20,
    parameter int ALLRED_CYCLES     = 10,
    parameter int FLASH_HALF_CYCLES = 25,
    parameter int CNT_W             = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    multiway_traffic_controller_if.slave  bus
);

    localparam int DIR_W = dir_width(NUM_DIRS);

    localparam int unsigned MIN_M1   = MIN_GREEN_CYCLES - 1;
    localparam int unsigned MAX_M1   = MAX_GREEN_CYCLES - 1;
    localparam int unsigned YEL_M1   = YELLOW_CYCLES - 1;
    localparam int unsigned ARED_M1  = ALLRED_CYCLES - 1;
    localparam int unsigned FLASH_M1 = FLASH_HALF_CYCLES - 1;

    if (NUM_DIRS < 2 || NUM_DIRS > 8) begin : g_bad_dirs
        $error("NUM_DIRS must be in 2..8");
    end
    if (MIN_GREEN_CYCLES < 1 || MAX_GREEN_CYCLES < MIN_GREEN_CYCLES) begin : g_bad_green
        $error("green limits must satisfy 1 <= MIN_GREEN_CYCLES <= MAX_GREEN_CYCLES");
    end
    if (YELLOW_CYCLES < 1 || ALLRED_CYCLES < 1 || FLASH_HALF_CYCLES < 1) begin : g_bad_times
        $error("YELLOW_CYCLES, ALLRED_CYCLES and FLASH_HALF_CYCLES must be >= 1");
    end
    if (longint'(MAX_GREEN_CYCLES - 1) >= (longint'(1) << CNT_W) ||
        longint'(FLASH_HALF_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
        $error("CNT_W too narrow for MAX_GREEN_CYCLES-1 / FLASH_HALF_CYCLES-1");
    end

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [DIR_W-1:0]   active_q, active_d;
    logic [DIR_W-1:0]   next_q, next_d;
    logic               flash_on_q, flash_on_d;

    logic [31:0]         cnt32;
    logic [NUM_DIRS-1:0] conflict;
    logic [DIR_W-1:0]    rr_next;
    logic                rr_valid;
    logic [DIR_W-1:0]    active_inc;
    logic                green_exit;
    logic                illegal;
    logic [2:0]          lamp;

    assign cnt32      = 32'(counter_q);
    assign conflict   = bus.demand & ~(NUM_DIRS'(1) << active_q);
    assign active_inc = DIR_W'((32'(active_q) + 32'd1) % 32'(NUM_DIRS));

    rr_next_dir #(
        .NUM_DIRS (NUM_DIRS),
        .DIR_W    (DIR_W)
    ) u_rr (
        .req_i   (conflict),
        .cur_i   (active_q),
        .next_o  (rr_next),
        .valid_o (rr_valid)
    );

    // Direction registers can only hold out-of-range codes when NUM_DIRS is not a power of two.
    if ((1 << DIR_W) != NUM_DIRS) begin : g_range_chk
        assign illegal = (32'(active_q) >= 32'(NUM_DIRS)) || (32'(next_q) >= 32'(NUM_DIRS));
    end else begin : g_range_ok
        assign illegal = 1'b0;
    end

    assign green_exit = bus.flash_req ||
                        ((|conflict) && ((cnt32 >= MIN_M1 && !bus.demand[active_q]) ||
                                         (cnt32 >= MAX_M1)));

    always_comb begin
        phase_d    = phase_q;
        counter_d  = counter_q;
        active_d   = active_q;
        next_d     = next_q;
        flash_on_d = flash_on_q;
        case (phase_q)
            PH_GREEN: begin
                if (cnt32 < MAX_M1) counter_d = counter_q + CNT_W'(1);
                if (green_exit) begin
                    phase_d   = PH_YELLOW;
                    counter_d = '0;
                    next_d    = rr_valid ? rr_next : active_inc;
                end
            end
            PH_YELLOW: begin
                if (cnt32 >= YEL_M1) begin
                    phase_d   = PH_ALLRED;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            PH_ALLRED: begin
                if (cnt32 >= ARED_M1) begin
                    counter_d = '0;
                    if (bus.flash_req) begin
                        phase_d    = PH_FLASH;
                        flash_on_d = 1'b1;
                    end else begin
                        phase_d  = PH_GREEN;
                        active_d = next_q;
                    end
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            PH_FLASH: begin
                if (!bus.flash_req) begin
                    phase_d   = PH_ALLRED;
                    counter_d = '0;
                    next_d    = '0;
                end else if (cnt32 >= FLASH_M1) begin
                    counter_d  = '0;
                    flash_on_d = ~flash_on_q;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || illegal) begin
            phase_q    <= PH_ALLRED;
            counter_q  <= '0;
            active_q   <= '0;
            next_q     <= '0;
            flash_on_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            counter_q  <= counter_d;
            active_q   <= active_d;
            next_q     <= next_d;
            flash_on_q <= flash_on_d;
        end
    end

    always_comb begin
        bus.lights = '0;
        lamp       = LAMP_RED;
        for (int i = 0; i < NUM_DIRS; i++) begin
            lamp = LAMP_RED;
            case (phase_q)
                PH_GREEN:  if (active_q == DIR_W'(i)) lamp = LAMP_GRN;
                PH_YELLOW: if (active_q == DIR_W'(i)) lamp = LAMP_YEL;
                PH_FLASH:  lamp = flash_on_q ? LAMP_RED : LAMP_OFF;
                default:   lamp = LAMP_RED;
            endcase
            bus.lights[3*i +: 3] = lamp;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.active_dir = active_q;

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// Scenario bench for multiway_traffic_controller: expected per-cycle phase/direction/lamps
// are queued from the intended timing and compared cycle by cycle against the outputs.
module tb_multiway_traffic_controller;
    import traffic_pkg::*;

    localparam int ND = 4;

    logic clk;
    logic rst;

    multiway_traffic_controller_if #(.NUM_DIRS(ND)) bus ();

    multiway_traffic_controller #(
        .NUM_DIRS          (ND),
        .MIN_GREEN_CYCLES  (5),
        .MAX_GREEN_CYCLES  (12),
        .YELLOW_CYCLES     (3),
        .ALLRED_CYCLES     (2),
        .FLASH_HALF_CYCLES (4),
        .CNT_W             (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // {phase, active_dir, lights}
    logic [15:0] sbq[$];
    logic [15:0] e;
    logic [15:0] obs;

    function automatic logic [15:0] exp_v(input logic [1:0] ph, input logic [1:0] dir,
                                          input logic fon);
        logic [11:0] l;
        for (int i = 0; i < ND; i++) begin
            logic [2:0] c;
            c = LAMP_RED;
            if (ph == PH_GREEN  && dir == 2'(i)) c = LAMP_GRN;
            if (ph == PH_YELLOW && dir == 2'(i)) c = LAMP_YEL;
            if (ph == PH_FLASH) c = fon ? LAMP_RED : LAMP_OFF;
            l[3*i +: 3] = c;
        end
        return {ph, dir, l};
    endfunction

    task automatic push(input logic [1:0] ph, input logic [1:0] dir, input logic fon,
                        input int n);
        repeat (n) sbq.push_back(exp_v(ph, dir, fon));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input logic [3:0] dem);
        sbq.delete();
        bus.demand    = dem;
        bus.flash_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.demand    = '0;
        bus.flash_req = 1'b0;
        rst = 1'b1;
        step();
        n_chk++;
        if (bus.phase !== PH_ALLRED || bus.active_dir !== 2'd0 || bus.lights !== 12'h924) begin
            n_fail++;
            $display("FAIL reset_state: got ph=%0d dir=%0d lights=%h, want ph=2 dir=0 lights=924",
                     bus.phase, bus.active_dir, bus.lights);
        end
        rst = 1'b0;
        push(PH_ALLRED, 0, 0, 1);
        push(PH_GREEN, 0, 0, 101);
        while (sbq.size() > 0) begin
            step();
            e   = sbq.pop_front();
            obs = {bus.phase, bus.active_dir, bus.lights};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_rest cyc %0d: got %h want %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_actuation();
        // Continues from a long-resting dir0 green.
        bus.demand = 4'b0100;
        push(PH_YELLOW, 0, 0, 3);
        push(PH_ALLRED, 0, 0, 2);
        push(PH_GREEN, 2, 0, 6);
        while (sbq.size() > 0) begin
            step();
            e   = sbq.pop_front();
            obs = {bus.phase, bus.active_dir, bus.lights};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL actuation cyc %0d: got %h want %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_max_green();
        apply_reset(4'b0011);
        push(PH_ALLRED, 0, 0, 1);
        repeat (2) begin
            push(PH_GREEN, 0, 0, 12); push(PH_YELLOW, 0, 0, 3); push(PH_ALLRED, 0, 0, 2);
            push(PH_GREEN, 1, 0, 12); push(PH_YELLOW, 1, 0, 3); push(PH_ALLRED, 1, 0, 2);
        end
        push(PH_GREEN, 0, 0, 12);
        while (sbq.size() > 0) begin
            step();
            e   = sbq.pop_front();
            obs = {bus.phase, bus.active_dir, bus.lights};
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL max_green cyc %0d: got %h want %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_min_green();
        apply_reset(4'b0000);
        push(PH_ALLRED, 0, 0, 1);
        push(PH_GREEN, 0, 0, 1);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                bus.demand = 4'b0010;
                push(PH_GREEN, 0, 0, 4);
                push(PH_YELLOW, 0, 0, 3);
                push(PH_ALLRED, 0, 0, 2);
                push(PH_GREEN, 1, 0, 4);
            end
            while (sbq.size() > 0) begin
                step();
                e   = sbq.pop_front();
                obs = {bus.phase, bus.active_dir, bus.lights};
                n_chk++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL min_green cyc %0d: got %h want %h", cyc, obs, e);
                end
            end
        end
    endtask

    task automatic test_flash();
        apply_reset(4'b0000);
        push(PH_ALLRED, 0, 0, 1);
        push(PH_GREEN, 0, 0, 2);
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 1) begin
                bus.flash_req = 1'b1;
                push(PH_YELLOW, 0, 0, 3);
                push(PH_ALLRED, 0, 0, 2);
                push(PH_FLASH, 0, 1, 4);
                push(PH_FLASH, 0, 0, 4);
                push(PH_FLASH, 0, 1, 4);
            end
            if (ph == 2) begin
                bus.flash_req = 1'b0;
                push(PH_ALLRED, 0, 0, 2);
                push(PH_GREEN, 0, 0, 4);
            end
            while (sbq.size() > 0) begin
                step();
                e   = sbq.pop_front();
                obs = {bus.phase, bus.active_dir, bus.lights};
                n_chk++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL flash cyc %0d: got %h want %h", cyc, obs, e);
                end
            end
        end
    endtask

    task automatic test_reset_midphase();
        apply_reset(4'b0010);
        push(PH_ALLRED, 0, 0, 1);
        push(PH_GREEN, 0, 0, 5);
        push(PH_YELLOW, 0, 0, 3);
        push(PH_ALLRED, 0, 0, 2);
        push(PH_GREEN, 1, 0, 6);
        for (int ph = 0; ph < 4; ph++) begin
            if (ph == 1) begin
                bus.demand = 4'b0001;
                push(PH_YELLOW, 1, 0, 1);
            end
            if (ph == 2) begin
                rst = 1'b1;
                push(PH_ALLRED, 0, 0, 1);
            end
            if (ph == 3) begin
                rst = 1'b0;
                push(PH_ALLRED, 0, 0, 1);
                push(PH_GREEN, 0, 0, 3);
            end
            while (sbq.size() > 0) begin
                step();
                e   = sbq.pop_front();
                obs = {bus.phase, bus.active_dir, bus.lights};
                n_chk++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL reset_mid cyc %0d: got %h want %h", cyc, obs, e);
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.demand    = '0;
        bus.flash_req = 1'b0;
        test_reset();
        test_actuation();
        test_max_green();
        test_min_green();
        test_flash();
        test_reset_midphase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
